// File: rtl/cpu_pkg.sv
//==== cpu_pkg | shared pipeline hazard types and helpers | rev 1.0 ====
`default_nettype none

package cpu_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG   = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } hz_stage_t;

  function automatic logic is_writer(hz_stage_t s, logic [REG_ADDR_W-1:0] zr);
    return s.valid && s.reg_write && (s.rd != zr);
  endfunction

  // Nearer stage (EX) takes priority; WB is covered by register-file write-through.
  function automatic fwd_sel_t fwd_pick(logic uses, logic [REG_ADDR_W-1:0] src,
                                        hz_stage_t ex, hz_stage_t mem,
                                        logic [REG_ADDR_W-1:0] zr);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (uses && is_writer(ex, zr) && (ex.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (uses && is_writer(mem, zr) && (mem.rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hz_stage_reg.sv
//==== hz_stage_reg | one shadow pipeline stage with bubble insert | rev 1.0 ====
`default_nettype none

module hz_stage_reg
  import cpu_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      bubble_i,
  input  hz_stage_t d_i,
  output hz_stage_t q_o
);

  hz_stage_t stage_q;
  hz_stage_t stage_d;

  always_comb begin
    stage_d = d_i;
    if (bubble_i) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
//==== fwd_hazard_unit | EX operand forwarding selects and load-use stall | rev 1.0 ====
`default_nettype none

module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rn_i,
  input  logic [REG_ADDR_W-1:0] id_rm_i,
  input  logic                  id_uses_rn_i,
  input  logic                  id_uses_rm_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  br_taken_i,
  output logic                  stall_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [CNT_W-1:0]      stall_count_o
);

  localparam logic [REG_ADDR_W-1:0] ZR = ZERO_REG[REG_ADDR_W-1:0];

  // Index 0 = EX, 1 = MEM, 2 = WB.
  hz_stage_t stage_d     [3];
  hz_stage_t stage_q     [3];
  logic      stage_bubble[3];

  hz_stage_t ex_q;
  hz_stage_t mem_q;
  logic      ex_bubble;

  fwd_sel_t          fwd_a_q, fwd_a_d;
  fwd_sel_t          fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  assign ex_q  = stage_q[0];
  assign mem_q = stage_q[1];

  always_comb begin
    stall_o = id_valid_i && !br_taken_i && ex_q.valid && ex_q.mem_read && (ex_q.rd != ZR) &&
              ((id_uses_rn_i && (id_rn_i == ex_q.rd)) || (id_uses_rm_i && (id_rm_i == ex_q.rd)));
  end

  assign ex_bubble = stall_o || br_taken_i;

  always_comb begin
    stage_d[0]      = {id_valid_i, id_rd_i, id_reg_write_i, id_mem_read_i};
    stage_bubble[0] = ex_bubble;
    for (int i = 1; i < 3; i++) begin
      stage_d[i]      = stage_q[i-1];
      stage_bubble[i] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    hz_stage_reg u_stage (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .bubble_i (stage_bubble[gi]),
      .d_i      (stage_d[gi]),
      .q_o      (stage_q[gi])
    );
  end

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!ex_bubble && id_valid_i) begin
      fwd_a_d = fwd_pick(id_uses_rn_i, id_rn_i, ex_q, mem_q, ZR);
      fwd_b_d = fwd_pick(id_uses_rm_i, id_rm_i, ex_q, mem_q, ZR);
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      stall_count_q <= '0;
    end else begin
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a_sel_o   = fwd_a_q;
  assign fwd_b_sel_o   = fwd_b_q;
  assign stall_count_o = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
//==== tb_fwd_hazard_unit | directed scoreboard bench for fwd_hazard_unit | rev 1.0 ====
`default_nettype none

module tb_fwd_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rn = '0, id_rm = '0, id_rd = '0;
  logic          id_uses_rn = 1'b0, id_uses_rm = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0, br_taken = 1'b0;
  logic          stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int step_no = 0;
  int exp_cnt = 0;

  logic          q_stall[$];
  logic [1:0]    q_a[$];
  logic [1:0]    q_b[$];
  logic [CW-1:0] q_cnt[$];
  int            q_id[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .id_valid_i     (id_valid),
    .id_rn_i        (id_rn),
    .id_rm_i        (id_rm),
    .id_uses_rn_i   (id_uses_rn),
    .id_uses_rm_i   (id_uses_rm),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .br_taken_i     (br_taken),
    .stall_o        (stall),
    .fwd_a_sel_o    (fwd_a_sel),
    .fwd_b_sel_o    (fwd_b_sel),
    .stall_count_o  (stall_count)
  );

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
  endtask

  // Drive one ID-stage cycle; expected stall is for this cycle, the rest for after the edge.
  task automatic step(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                      input logic urn, input logic urm, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic br, input logic rst,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb,
                      input logic [CW-1:0] ec);
    @(negedge clk);
    id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; br_taken = br; reset = rst;
    step_no++;
    q_stall.push_back(es); q_a.push_back(ea); q_b.push_back(eb);
    q_cnt.push_back(ec); q_id.push_back(step_no);
  endtask

  initial begin : monitor
    int id; logic es; logic [1:0] ea, eb; logic [CW-1:0] ec;
    forever begin
      @(negedge clk); #1;
      if (q_id.size() > 0) begin
        id = q_id.pop_front(); es = q_stall.pop_front();
        ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_cnt.pop_front();
        chk("stall", id, {15'd0, stall}, {15'd0, es});
        @(posedge clk); #1;
        chk("fwd_a_sel", id, {14'd0, fwd_a_sel}, {14'd0, ea});
        chk("fwd_b_sel", id, {14'd0, fwd_b_sel}, {14'd0, eb});
        chk("stall_count", id, {12'd0, stall_count}, {12'd0, ec});
      end
    end
  end

  initial begin : driver
    int guard;
    // v  rn  rm urn urm rd rw mr br rst | stall a b cnt
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // EX/MEM forward on operand A
    step(1, 2, 3, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);   // ADD X1,X2,X3
    step(1, 1, 5, 1, 1, 4, 1, 0, 0, 0,   0, 1, 0, 0);   // SUB X4,X1,X5
    // MEM/WB forward on operand B
    step(1, 2, 3, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);   // ADD X1
    step(1, 2, 3, 1, 1, 8, 1, 0, 0, 0,   0, 0, 0, 0);   // AND X8
    step(1, 7, 1, 1, 1, 6, 1, 0, 0, 0,   0, 0, 2, 0);   // ORR X6,X7,X1
    // load-use: one stall then MEM/WB on both operands
    step(1, 2, 0, 1, 0, 9, 1, 1, 0, 0,   0, 0, 0, 0);   // LDUR X9
    step(1, 9, 9, 1, 1, 10, 1, 0, 0, 0,  1, 0, 0, 1);   // ADD X10,X9,X9 stalled
    step(1, 9, 9, 1, 1, 10, 1, 0, 0, 0,  0, 2, 2, 1);   // ADD advances
    // XZR never forwards or stalls
    step(1, 2, 0, 1, 0, 31, 1, 1, 0, 0,  0, 0, 0, 1);   // LDUR X31
    step(1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1);   // consumer of X31
    step(1, 2, 3, 1, 1, 31, 1, 0, 0, 0,  0, 0, 0, 1);   // ADD X31
    step(1, 31, 31, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1);   // consumer of X31
    // flush overrides load-use
    step(1, 2, 0, 1, 0, 12, 1, 1, 0, 0,  0, 0, 0, 1);   // LDUR X12
    step(1, 12, 2, 1, 1, 13, 1, 0, 1, 0, 0, 0, 0, 1);   // consumer + br_taken
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    // load, unrelated, consumer: no stall, MEM/WB select
    step(1, 2, 0, 1, 0, 14, 1, 1, 0, 0,  0, 0, 0, 1);   // LDUR X14
    step(1, 2, 3, 1, 1, 15, 1, 0, 0, 0,  0, 0, 0, 1);   // AND X15
    step(1, 14, 2, 1, 1, 16, 1, 0, 0, 0, 0, 2, 0, 1);   // ADD X16,X14,X2
    // mid-stream reset with X3 writers in EX and MEM
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 1);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, 0,   0, 0, 0, 0);   // ADD X4,X3,X3
    // saturate the stall counter
    exp_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      step(1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, exp_cnt[CW-1:0]);
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      step(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 1, 0, 0, exp_cnt[CW-1:0]);
      step(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, 2, 2, exp_cnt[CW-1:0]);
    end
    guard = 0;
    while (q_id.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    if (q_id.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expected responses left, required 0", q_id.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard control for the 5-stage 64-bit pipeline.
- Tracks destination-register info for the instructions in the EX, MEM and WB stages.
- Drives the select pairs of the EX-stage operand forwarding muxes, which are built from mux2_1 cells, and issues the load-use stall to IF/ID.
- Sits between ID decode and the EX operand mux trees.

Parameters:
REG_ADDR_W, 5, register address width
ZERO_REG, 31, XZR index; never a forwarding source and never a hazard
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_rn  input  REG_ADDR_W  source register A
id_rm  input  REG_ADDR_W  source register B (Rd for STUR/CBZ, per decode)
id_uses_rn  input  1  operand A is read
id_uses_rm  input  1  operand B is read
id_rd  input  REG_ADDR_W  destination register
id_reg_write  input  1  instruction writes the register file
id_mem_read  input  1  instruction is a load (LDUR)
br_taken  input  1  branch resolved taken; squash ID
stall  output  1  hold PC and IF/ID; combinational
fwd_a_sel  output  2  operand A mux select for the instruction now in EX
fwd_b_sel  output  2  operand B mux select for the instruction now in EX
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow stages: ex, mem, wb. Each holds valid, rd, reg_write and mem_read.
- Every posedge: wb <= mem, mem <= ex.
- ex <= bubble (valid=0) if stall or br_taken; otherwise ex <= ID fields gated by id_valid.
- A stage counts as a "writer" when: valid && reg_write && rd != ZERO_REG.
- Select encoding:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB write-back data.
  - 11: never driven.
- fwd_*_sel are registered and computed at the edge on which ID advances into EX. For operand A:
  - 01 if uses_rn and current ex is a writer with rd==rn.
  - Else 10 if current mem is a writer with rd==rn.
  - Else 00.
  - Nearer stage wins.
  - Operand B is computed identically with rm.
- When a bubble is loaded into ex, both selects <= 00.
- WB-stage hazards are not forwarded. The register file provides same-cycle write-through.
- stall (combinational) = id_valid && !br_taken && ex.valid && ex.mem_read && ex.rd != ZERO_REG && ((id_uses_rn && id_rn==ex.rd) || (id_uses_rm && id_rm==ex.rd)).
- Stall lasts exactly 1 cycle per load-use pair. After the bubble, the load is in mem, and the consumer gets sel 10 on entering EX.
- Load followed by a consumer 2 instructions later: no stall; sel 10.
- Simultaneous stall condition and br_taken: flush wins, stall=0, ex <= bubble.
- stall_count increments on every cycle where stall=1. It saturates at all-ones and never wraps.
- Reset (synchronous, mid-operation included): all shadow valids 0, fwd_a_sel=fwd_b_sel=00, stall_count=0. Hence stall=0 in the cycle after reset.
- No latches; all state updates on posedge clk only.

Decomposition:
- Shared package cpu_pkg holds:
  - fwd_sel_t: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - ZERO_REG constant.
  - hz_stage_t: packed struct {valid, rd, reg_write, mem_read}.
- One sub-module, hz_stage_reg: a single shadow-stage register with synchronous reset and a bubble input. Instantiated 3 times.

Test Plan:
- ADD X1,X2,X3 followed by SUB X4,X1,X5 (id_rn=1) -> no stall; fwd_a_sel=01 during SUB's EX cycle, fwd_b_sel=00.
- ADD X1 writer, an unrelated instruction, then ORR X6,X7,X1 (id_rm=1) -> fwd_b_sel=10, fwd_a_sel=00.
- LDUR X9 followed by ADD X10,X9,X9 -> stall=1 for exactly 1 cycle, stall_count=1. The ADD then enters EX with fwd_a_sel=fwd_b_sel=10.
- LDUR X31 followed by a consumer of X31, and ADD X31 followed by a consumer of X31 -> stall=0, selects 00.
- Load-use condition with br_taken=1 in the same cycle -> stall=0, ex bubble, next-cycle selects 00, stall_count unchanged.
- Reset asserted mid-stream with ex and mem holding writers of X3, then ID reads X3 -> selects 00, stall=0. Also preload stall_count to all-ones via repeated stalls -> it holds at all-ones.
